// File: rtl/jtriders_palsched.sv
// jtriders_palsched: one single-port palette RAM shared by video, dump, CPU.
// Slot priority per clk: video pixel > ioctl dump > CPU access.
module jtriders_palsched #(
  parameter int AW    = 11,
  parameter int WAITW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen,
  input  logic [AW-1:0]    vid_addr,
  output logic [15:0]      vid_data,
  input  logic             cpu_cs,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [1:0]       cpu_dsn,
  input  logic [15:0]      cpu_dout,
  output logic [15:0]      cpu_din,
  output logic             cpu_ok,
  input  logic             ioctl_ram,
  input  logic [AW:0]      ioctl_addr,
  output logic [7:0]       ioctl_din,
  output logic [AW-1:0]    ram_addr,
  output logic [1:0]       ram_we,
  output logic [15:0]      ram_din,
  input  logic [15:0]      ram_dout,
  output logic [WAITW-1:0] cpu_stall
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       r_st;
  logic [WAITW-1:0] r_stall;
  logic             r_wr;
  logic             r_abort;
  logic [1:0]       r_vid_p;
  logic [1:0]       r_dmp_p;
  logic [15:0]      r_dump;

  logic             w_vid_win;
  logic             w_dmp_win;
  logic             w_cpu_win;
  logic             w_cpu_end;
  logic [WAITW-1:0] w_stall_max;

  assign w_vid_win   = pxl_cen;
  assign w_dmp_win   = ~pxl_cen & ioctl_ram;
  assign w_cpu_win   = ~pxl_cen & ~ioctl_ram
                     & (r_st == ST_ISSUE) & cpu_cs;
  assign w_cpu_end   = ~cpu_cs | r_abort;
  assign w_stall_max = {WAITW{1'b1}};

  assign cpu_ok    = (r_st == ST_DONE);
  assign ioctl_din = ioctl_addr[0] ? r_dump[7:0] : r_dump[15:8];

  // RAM port: register the winning requester's address/strobes/data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr <= '0;
      ram_we   <= 2'b00;
      ram_din  <= 16'h0000;
    end else begin
      ram_we <= 2'b00;
      unique case (1'b1)
        w_vid_win: ram_addr <= vid_addr;
        w_dmp_win: ram_addr <= ioctl_addr[AW:1];
        w_cpu_win: begin
          ram_addr <= cpu_addr;
          if (cpu_we) begin
            ram_we  <= ~cpu_dsn;
            ram_din <= cpu_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-return tracking: data is back two edges after the slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vid_p <= 2'b00;
      r_dmp_p <= 2'b00;
    end else begin
      r_vid_p <= {r_vid_p[0], w_vid_win};
      r_dmp_p <= {r_dmp_p[0], w_dmp_win};
    end
  end

  // Video capture, fixed two-edge latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vid_data <= 16'h0000;
    end else if (r_vid_p[1]) begin
      vid_data <= ram_dout;
    end
  end

  // Dump capture, refreshed on every dump slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dump <= 16'h0000;
    end else if (r_dmp_p[1]) begin
      r_dump <= ram_dout;
    end
  end

  // CPU access FSM with stall counting and abort handling
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st      <= ST_IDLE;
      r_stall   <= '0;
      r_wr      <= 1'b0;
      r_abort   <= 1'b0;
      cpu_din   <= 16'h0000;
      cpu_stall <= '0;
    end else begin
      unique case (r_st)
        ST_IDLE: begin
          if (cpu_cs) begin
            r_st    <= ST_ISSUE;
            r_stall <= '0;
            r_abort <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!cpu_cs) begin
            r_st <= ST_IDLE;
          end else if (w_cpu_win) begin
            r_wr <= cpu_we;
            r_st <= ST_WAIT;
          end else if (r_stall != w_stall_max) begin
            r_stall <= r_stall + WAITW'(1);
          end
        end
        ST_WAIT: begin
          if (r_wr) begin
            if (w_cpu_end) begin
              r_st <= ST_IDLE;
            end else begin
              r_st      <= ST_DONE;
              cpu_stall <= r_stall;
            end
          end else begin
            r_abort <= r_abort | ~cpu_cs;
            r_st    <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          cpu_din <= ram_dout;
          if (w_cpu_end) begin
            r_st <= ST_IDLE;
          end else begin
            r_st      <= ST_DONE;
            cpu_stall <= r_stall;
          end
        end
        ST_DONE: begin
          if (!cpu_cs) r_st <= ST_IDLE;
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtriders_palsched.sv
// tb_jtriders_palsched: scenario tasks with a behavioural palette RAM.
// Expected read data is queued at stimulus time and popped on completion.
module tb_jtriders_palsched;

  localparam int AW    = 11;
  localparam int WAITW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pxl_cen;
  logic [AW-1:0]    vid_addr;
  logic [15:0]      vid_data;
  logic             cpu_cs;
  logic             cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [1:0]       cpu_dsn;
  logic [15:0]      cpu_dout;
  logic [15:0]      cpu_din;
  logic             cpu_ok;
  logic             ioctl_ram;
  logic [AW:0]      ioctl_addr;
  logic [7:0]       ioctl_din;
  logic [AW-1:0]    ram_addr;
  logic [1:0]       ram_we;
  logic [15:0]      ram_din;
  logic [15:0]      ram_dout;
  logic [WAITW-1:0] cpu_stall;

  logic [15:0] mem [0:2047];
  logic        pl_en = 1'b0;
  logic [10:0] pl_a;
  logic [15:0] pl_d;

  logic [15:0] q_vid [$];
  logic [15:0] q_cpu [$];

  int n_tests = 0;
  int n_fail  = 0;

  jtriders_palsched #(.AW(AW), .WAITW(WAITW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pxl_cen(pxl_cen), .vid_addr(vid_addr), .vid_data(vid_data),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_dsn(cpu_dsn), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_ok(cpu_ok), .ioctl_ram(ioctl_ram), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM, data one clk after the address edge
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
    if (ram_we[1]) mem[ram_addr][15:8] <= ram_din[15:8];
    if (pl_en) mem[pl_a] <= pl_d;
  end

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (vid_data !== 16'h0) begin n_fail++;
      $display("FAIL rst vid_data got %h want 0000", vid_data); end
    n_tests++;
    if (cpu_din !== 16'h0) begin n_fail++;
      $display("FAIL rst cpu_din got %h want 0000", cpu_din); end
    n_tests++;
    if (cpu_ok !== 1'b0) begin n_fail++;
      $display("FAIL rst cpu_ok got %b want 0", cpu_ok); end
    n_tests++;
    if (ioctl_din !== 8'h0) begin n_fail++;
      $display("FAIL rst ioctl_din got %h want 00", ioctl_din); end
    n_tests++;
    if (ram_addr !== 11'h0) begin n_fail++;
      $display("FAIL rst ram_addr got %h want 000", ram_addr); end
    n_tests++;
    if (ram_we !== 2'b00) begin n_fail++;
      $display("FAIL rst ram_we got %b want 00", ram_we); end
    n_tests++;
    if (ram_din !== 16'h0) begin n_fail++;
      $display("FAIL rst ram_din got %h want 0000", ram_din); end
    n_tests++;
    if (cpu_stall !== 4'h0) begin n_fail++;
      $display("FAIL rst cpu_stall got %h want 0", cpu_stall); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_video;
    logic [10:0] addrs [3];
    logic [15:0] datas [3];
    logic [15:0] prev;
    logic [15:0] exp;
    addrs = '{11'h123, 11'h2A0, 11'h001};
    datas = '{16'h7FFF, 16'h0F0F, 16'hC3A5};
    for (int i = 0; i < 3; i++) poke(addrs[i], datas[i]);
    prev = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pxl_cen = 1'b1; vid_addr = addrs[i];
      q_vid.push_back(datas[i]);
      @(negedge clk);
      pxl_cen = 1'b0;
      @(negedge clk);
      n_tests++;
      if (vid_data !== prev) begin n_fail++;
        $display("FAIL vid early[%0d] got %h want %h", i, vid_data, prev); end
      @(negedge clk);
      exp = q_vid.pop_front();
      n_tests++;
      if (vid_data !== exp) begin n_fail++;
        $display("FAIL vid data[%0d] got %h want %h", i, vid_data, exp); end
      prev = exp;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        n_tests++;
        if (ram_we !== 2'b00 || vid_data !== prev) begin n_fail++;
          $display("FAIL vid hold[%0d] we %b data %h want 00 %h",
                   i, ram_we, vid_data, prev); end
      end
    end
  endtask

  task automatic test_cpu_read;
    int k;
    logic [15:0] exp;
    poke(11'h7FF, 16'h1234);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF; cpu_dsn = 2'b00;
    q_cpu.push_back(16'h1234);
    k = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ok === 1'b1) begin k = c; break; end
    end
    n_tests++;
    if (k !== 3) begin n_fail++;
      $display("FAIL rd latency got %0d want 3", k); end
    exp = q_cpu.pop_front();
    n_tests++;
    if (cpu_din !== exp) begin n_fail++;
      $display("FAIL rd data got %h want %h", cpu_din, exp); end
    n_tests++;
    if (cpu_stall !== 4'd0) begin n_fail++;
      $display("FAIL rd stall got %0d want 0", cpu_stall); end
    @(negedge clk);
    n_tests++;
    if (cpu_ok !== 1'b1) begin n_fail++;
      $display("FAIL rd ok hold got %b want 1", cpu_ok); end
    cpu_cs = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cpu_ok !== 1'b0) begin n_fail++;
      $display("FAIL rd ok drop got %b want 0", cpu_ok); end
  endtask

  task automatic test_write_collide;
    logic [15:0] exp;
    poke(11'h045, 16'h1100);
    poke(11'h123, 16'h7FFF);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h045;
    cpu_dsn = 2'b10; cpu_dout = 16'hABCD;
    @(negedge clk);
    pxl_cen = 1'b1; vid_addr = 11'h123;
    q_vid.push_back(16'h7FFF);
    @(negedge clk);
    pxl_cen = 1'b0;
    n_tests++;
    if (ram_we !== 2'b00 || ram_addr !== 11'h123) begin n_fail++;
      $display("FAIL col vid slot we %b addr %h want 00 123",
               ram_we, ram_addr); end
    @(negedge clk);
    n_tests++;
    if (ram_we !== 2'b01 || ram_din !== 16'hABCD
        || ram_addr !== 11'h045 || cpu_ok !== 1'b0) begin n_fail++;
      $display("FAIL col wr slot we %b din %h addr %h ok %b want 01 abcd 045 0",
               ram_we, ram_din, ram_addr, cpu_ok); end
    @(negedge clk);
    n_tests++;
    if (cpu_ok !== 1'b1 || ram_we !== 2'b00) begin n_fail++;
      $display("FAIL col done ok %b we %b want 1 00", cpu_ok, ram_we); end
    n_tests++;
    if (cpu_stall !== 4'd1) begin n_fail++;
      $display("FAIL col stall got %0d want 1", cpu_stall); end
    exp = q_vid.pop_front();
    n_tests++;
    if (vid_data !== exp) begin n_fail++;
      $display("FAIL col vid got %h want %h", vid_data, exp); end
    cpu_cs = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem[11'h045] !== 16'h11CD) begin n_fail++;
      $display("FAIL col mem got %h want 11cd", mem[11'h045]); end
  endtask

  task automatic test_write_nostrobe;
    int k;
    int bad;
    poke(11'h046, 16'h5555);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h046;
    cpu_dsn = 2'b11; cpu_dout = 16'hFFFF;
    k = -1; bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ram_we !== 2'b00) bad++;
      if (cpu_ok === 1'b1) begin k = c; break; end
    end
    n_tests++;
    if (k !== 2) begin n_fail++;
      $display("FAIL wr11 latency got %0d want 2", k); end
    n_tests++;
    if (bad !== 0) begin n_fail++;
      $display("FAIL wr11 ram_we active %0d cycles want 0", bad); end
    cpu_cs = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem[11'h046] !== 16'h5555) begin n_fail++;
      $display("FAIL wr11 mem got %h want 5555", mem[11'h046]); end
  endtask

  task automatic test_dump;
    int k;
    int bad;
    logic [15:0] exp;
    poke(11'h005, 16'h5AA5);
    poke(11'h006, 16'h3C96);
    poke(11'h200, 16'hBEEF);
    @(negedge clk);
    ioctl_ram = 1'b1; ioctl_addr = 12'h00B;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ioctl_din !== 8'hA5) begin n_fail++;
      $display("FAIL dump lo got %h want a5", ioctl_din); end
    ioctl_addr = 12'h00A;
    #1;
    n_tests++;
    if (ioctl_din !== 8'h5A) begin n_fail++;
      $display("FAIL dump hi got %h want 5a", ioctl_din); end
    @(negedge clk);
    ioctl_addr = 12'h00C;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ioctl_din !== 8'h3C) begin n_fail++;
      $display("FAIL dump track got %h want 3c", ioctl_din); end
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200; cpu_dsn = 2'b00;
    q_cpu.push_back(16'hBEEF);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ok !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++;
      $display("FAIL dump starve ok seen %0d cycles want 0", bad); end
    ioctl_ram = 1'b0;
    k = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ok === 1'b1) begin k = c; break; end
    end
    n_tests++;
    if (k !== 2) begin n_fail++;
      $display("FAIL dump resume latency got %0d want 2", k); end
    exp = q_cpu.pop_front();
    n_tests++;
    if (cpu_din !== exp) begin n_fail++;
      $display("FAIL dump cpu data got %h want %h", cpu_din, exp); end
    n_tests++;
    if (cpu_stall !== 4'd15) begin n_fail++;
      $display("FAIL dump stall got %0d want 15", cpu_stall); end
    cpu_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int bad;
    poke(11'h047, 16'h2222);
    @(negedge clk);
    ioctl_ram = 1'b1; ioctl_addr = 12'h08E;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h047;
    cpu_dsn = 2'b00; cpu_dout = 16'hDEAD;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ok !== 1'b0 || ram_we !== 2'b00) bad++;
    end
    cpu_cs = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (cpu_ok !== 1'b0 || ram_we !== 2'b00) bad++;
    end
    ioctl_ram = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ok !== 1'b0 || ram_we !== 2'b00) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++;
      $display("FAIL abort ok/we active %0d cycles want 0", bad); end
    n_tests++;
    if (mem[11'h047] !== 16'h2222) begin n_fail++;
      $display("FAIL abort mem got %h want 2222", mem[11'h047]); end
  endtask

  task automatic test_reset_capt;
    int k;
    logic [15:0] exp;
    @(negedge clk);
    ioctl_addr = 12'h00D;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF; cpu_dsn = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (vid_data !== 16'h0 || cpu_din !== 16'h0 || cpu_ok !== 1'b0
        || ioctl_din !== 8'h0) begin n_fail++;
      $display("FAIL rcapt outA vid %h din %h ok %b io %h want 0",
               vid_data, cpu_din, cpu_ok, ioctl_din); end
    n_tests++;
    if (ram_addr !== 11'h0 || ram_we !== 2'b00 || ram_din !== 16'h0
        || cpu_stall !== 4'h0) begin n_fail++;
      $display("FAIL rcapt outB addr %h we %b din %h stall %h want 0",
               ram_addr, ram_we, ram_din, cpu_stall); end
    cpu_cs = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    cpu_cs = 1'b1;
    q_cpu.push_back(16'h1234);
    k = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ok === 1'b1) begin k = c; break; end
    end
    n_tests++;
    if (k !== 3) begin n_fail++;
      $display("FAIL rcapt idle latency got %0d want 3", k); end
    exp = q_cpu.pop_front();
    n_tests++;
    if (cpu_din !== exp) begin n_fail++;
      $display("FAIL rcapt data got %h want %h", cpu_din, exp); end
    cpu_cs = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; vid_addr = '0;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_dsn = 2'b11; cpu_dout = '0;
    ioctl_ram = 1'b0; ioctl_addr = '0;
    pl_a = '0; pl_d = '0;
    test_reset;
    test_video;
    test_cpu_read;
    test_write_collide;
    test_write_nostrobe;
    test_dump;
    test_abort;
    test_reset_capt;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtriders_palsched.md
# jtriders_palsched

Access scheduler for the 2048×16 colour-mixer palette RAM in the riders/xmen video path. It shares one synchronous single-port RAM between three requesters:
- video pixel lookups, hard real-time on every `pxl_cen`;
- 68000 CPU reads and byte-lane writes, using a level handshake;
- SD-card dump reads driven by `ioctl_ram`.

It sits between the 053251 priority output address, the CPU bus decoder and the palette RAM macro, so the palette no longer needs a dual-port RAM.

## Interface
Parameters:
- `AW`, 11: palette word-address width.
- `WAITW`, 4: width of the saturating stall counter.

Ports:
- `clk` in 1: video clock (48 MHz).
- `rst_n` in 1: reset, synchronous and active-low.
- `pxl_cen` in 1: pixel enable, single-cycle pulses, at least 2 `clk` apart.
- `vid_addr` in AW: palette index from the 053251, valid when `pxl_cen`=1.
- `vid_data` out 16: palette word for the last video request.
- `cpu_cs` in 1: palette access request, level-held.
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in AW: word address.
- `cpu_dsn` in 2: active-low byte strobes, {upper, lower}.
- `cpu_dout` in 16: write data.
- `cpu_din` out 16: read data.
- `cpu_ok` out 1: access complete, level.
- `ioctl_ram` in 1: dump mode.
- `ioctl_addr` in AW+1: byte address.
- `ioctl_din` out 8: dump byte.
- `ram_addr` out AW: RAM address.
- `ram_we` out 2: byte write enables, {upper, lower}.
- `ram_din` out 16: RAM write data.
- `ram_dout` in 16: RAM read data, valid 1 clk after the address edge.
- `cpu_stall` out WAITW: stall cycles of the last completed CPU access, saturating.

## Operation
- **Bus ownership** is re-decided at every `clk` edge E. Priority: video (`pxl_cen`=1 at E) > dump (`ioctl_ram`=1) > CPU (state ISSUE). The winner's `ram_addr`, `ram_we` and `ram_din` are registered at E. `ram_we` is non-zero only for a CPU write slot.
- **Video slot:** `ram_addr`<=`vid_addr`. At E+2, `vid_data`<=`ram_dout`. `vid_data` holds between requests.
- **Dump slot:**
  - `ram_addr`<=`ioctl_addr[AW:1]`; at E+2 the word is captured into the dump register.
  - `ioctl_din` = `ioctl_addr[0]` ? low byte : high byte of the captured word.
  - Dump mode re-reads every non-video cycle, so data tracks address changes after 2 free cycles.
- **CPU FSM:**
  - IDLE: `cs`=1 → ISSUE; the stall count is cleared.
  - ISSUE: the stall count increments for each lost slot. Slot won with a read → CAPT. Slot won with a write → drive `ram_we`=~`cpu_dsn` and `ram_din`=`cpu_dout` → DONE.
  - CAPT: `cpu_din`<=`ram_dout` → DONE.
  - DONE: `cpu_ok`=1; `cpu_stall`<=stall count. `cs`=0 sampled → IDLE, and `cpu_ok` clears at that edge.
- A write with `cpu_dsn`=2'b11 still consumes a slot, with `ram_we`=0, and completes normally.
- `cs` dropped in ISSUE: abandon the request, no RAM write, return to IDLE, `cpu_ok` stays 0.
- `cs` dropped in CAPT: finish the capture silently, then IDLE without asserting `cpu_ok`.
- A new access requires `cs` to deassert for at least 1 clk.
- `ioctl_ram`=1 starves the CPU, which waits in ISSUE. It resumes on the first free cycle after `ioctl_ram` falls.
- Address, data and strobes are sampled in the issue cycle and are not re-read later.

## Timing
- Reset, with `rst_n` low at an edge: FSM→IDLE and all outputs are 0 (`vid_data`, `cpu_din`, `cpu_ok`, `ioctl_din`, `ram_addr`, `ram_we`, `ram_din`, `cpu_stall`). Any in-flight access is dropped without a write. Reset asserted mid-write cancels a `ram_we` not yet registered.
- Video latency: `pxl_cen` at E → `vid_data` valid after E+2. The latency is fixed and never stretched.
- CPU read, no conflict: `cs` first sampled at E → issue at E+1 (IDLE→ISSUE at E), capture at E+3, `cpu_ok` high after E+3.
- CPU write, no conflict: `ram_we` high for the cycle after E+1, `cpu_ok` high after E+2.
- Each video slot taken while in ISSUE adds 1 clk of latency and increments the stall count. With spaced `pxl_cen` pulses the worst case outside dump mode is 1 stall.
- The stall count saturates at 2^WAITW−1 and never wraps.
- A video capture and a CPU/dump capture can complete at the same edge. They use independent registers and neither is lost.

## Test plan
- **Video only:** `pxl_cen` every 8 clk, `vid_addr`=0x123, RAM word 0x7FFF → `vid_data`=0x7FFF exactly 2 clk after each pulse; `ram_we` stays 0.
- **CPU write colliding with `pxl_cen`:** `cs`/`we` with addr 0x045, `dsn`=2'b10, dout 0xABCD, and `pxl_cen` at the issue edge → video slot first, then `ram_we`=2'b01 with `ram_din`=0xABCD one clk later; `cpu_ok` 1 clk later; `cpu_stall`=1.
- **CPU read, no conflict:** read of addr 0x7FF holding 0x1234 → `cpu_din`=0x1234 with `cpu_ok` 3 clk after `cs` is sampled; `cpu_ok` drops 1 clk after `cs` falls.
- **Dump priority:** `ioctl_ram`=1, `ioctl_addr`=0x00B, word at 0x005 = 0x5AA5 → `ioctl_din`=0xA5. A CPU read issued meanwhile stays without `cpu_ok` until `ioctl_ram`=0, then completes; `cpu_stall` saturates at 15.
- **Abort and reset:**
  - `cs` dropped in ISSUE during dump → no write occurs, `cpu_ok` is never asserted.
  - `rst_n` pulled low during CAPT → all outputs read 0 the next cycle and the FSM is in IDLE.
